// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: WIDTH-bit bitwise logic unit with an accumulator operand,
// behind a two-stage valid/ready pipeline that also produces zero/negative flags.
module logic_unit_pipe #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_PASB = 3'd7;

    function automatic logic [WIDTH-1:0] bitwise_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (sel)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_NOTA: r = ~x;
            OP_PASB: r = y;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] x);
        return (x == '0);
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s1_acc_sel_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] out_r;
    logic             zr_r;
    logic             ng_r;
    logic [WIDTH-1:0] acc_r;

    logic             in_accept_s;
    logic             s1_move_s;
    logic             in_ready_s;
    logic             out_accept_s;
    logic [WIDTH-1:0] a_eff_s;
    logic [WIDTH-1:0] result_s;
    logic             s1_valid_nx_s;
    logic             s2_valid_nx_s;
    logic [WIDTH-1:0] acc_nx_s;

    assign s1_move_s    = s1_valid_r & (~s2_valid_r | out_ready);
    assign in_ready_s   = ~s1_valid_r | s1_move_s;
    assign in_accept_s  = in_valid & in_ready_s;
    assign out_accept_s = s2_valid_r & out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign out       = out_r;
    assign zr        = zr_r;
    assign ng        = ng_r;

    // Operand select and result datapath for the op sitting in S1.
    always_comb begin
        a_eff_s  = '0;
        result_s = '0;
        if (s1_acc_sel_r) begin
            a_eff_s = acc_r;
        end else begin
            a_eff_s = s1_a_r;
        end
        result_s = bitwise_op(s1_op_r, a_eff_s, s1_b_r);
    end

    // Next-state for stage occupancy and the accumulator.
    always_comb begin
        s1_valid_nx_s = s1_valid_r;
        s2_valid_nx_s = s2_valid_r;
        acc_nx_s      = acc_r;
        if (in_accept_s) begin
            s1_valid_nx_s = 1'b1;
        end else if (s1_move_s) begin
            s1_valid_nx_s = 1'b0;
        end else begin
            s1_valid_nx_s = s1_valid_r;
        end
        // A refill from S1 keeps S2 occupied even when the consumer drains it.
        if (s1_move_s) begin
            s2_valid_nx_s = 1'b1;
        end else if (out_accept_s) begin
            s2_valid_nx_s = 1'b0;
        end else begin
            s2_valid_nx_s = s2_valid_r;
        end
        // Clear has priority over the result write-back.
        if (acc_clr) begin
            acc_nx_s = ACC_RESET;
        end else if (s1_move_s) begin
            acc_nx_s = result_s;
        end else begin
            acc_nx_s = acc_r;
        end
    end

    // Pipeline control state and accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            acc_r      <= ACC_RESET;
        end else begin
            s1_valid_r <= s1_valid_nx_s;
            s2_valid_r <= s2_valid_nx_s;
            acc_r      <= acc_nx_s;
        end
    end

    // S1 operand capture on accepted transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_r       <= '0;
            s1_b_r       <= '0;
            s1_op_r      <= 3'd0;
            s1_acc_sel_r <= 1'b0;
        end else if (in_accept_s) begin
            s1_a_r       <= a;
            s1_b_r       <= b;
            s1_op_r      <= op;
            s1_acc_sel_r <= acc_sel;
        end else begin
            s1_a_r       <= s1_a_r;
            s1_b_r       <= s1_b_r;
            s1_op_r      <= s1_op_r;
            s1_acc_sel_r <= s1_acc_sel_r;
        end
    end

    // S2 result and flag registers; they hold while stalled or empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
            zr_r  <= 1'b0;
            ng_r  <= 1'b0;
        end else if (s1_move_s) begin
            out_r <= result_s;
            zr_r  <= is_zero(result_s);
            ng_r  <= result_s[WIDTH-1];
        end else begin
            out_r <= out_r;
            zr_r  <= zr_r;
            ng_r  <= ng_r;
        end
    end

endmodule
